// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode/issue stage: widths, opcodes, instruction
// field positions and the decoded-control bundle.
package id_ex_stage_pkg;

  localparam int W  = 16;
  localparam int RA = 4;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       y_imm;    // Y comes from sext(imm4) instead of rt
    logic       rd_rt;    // destination is the rt field instead of [3:0]
    logic       wb_req;   // op writes back if its destination is not r0
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/id_ex_stage_op_decode.sv
// Combinational opcode decode: maps the 4-bit op onto operand-select and
// writeback/memory/branch control bits.
module op_decode
  import id_ex_stage_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = op;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
        dec.wb_req = 1'b1;
      end
      OP_LW: begin
        dec.y_imm  = 1'b1;
        dec.rd_rt  = 1'b1;
        dec.wb_req = 1'b1;
        dec.mem_rd = 1'b1;
      end
      OP_SW: begin
        dec.y_imm  = 1'b1;
        dec.mem_wr = 1'b1;
      end
      OP_BNE: begin
        dec.branch = 1'b1;
      end
      default: begin
        // Unknown ops still flow downstream but must be side-effect free.
        dec.illegal = 1'b1;
        dec.alu_op  = OP_AND;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue pipeline register feeding the 16-bit ALU: operand select with
// forwarding, single-entry valid/ready register, flush on taken branch.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int W  = id_ex_stage_pkg::W,
  parameter int RA = id_ex_stage_pkg::RA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  input  logic [15:0]   in_pc,
  output logic [RA-1:0] rs_addr,
  output logic [RA-1:0] rt_addr,
  input  logic [W-1:0]  rs_data,
  input  logic [W-1:0]  rt_data,
  input  logic          fwd_en,
  input  logic [RA-1:0] fwd_addr,
  input  logic [W-1:0]  fwd_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  alu_x,
  output logic [W-1:0]  alu_y,
  output logic [3:0]    alu_op,
  output logic          alu_cin,
  output logic [W-1:0]  store_data,
  output logic [RA-1:0] out_rd,
  output logic          wb_en,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          branch,
  output logic [15:0]   out_pc,
  output logic          illegal
);

  function automatic logic [W-1:0] operand_sel(input logic [RA-1:0] addr,
                                               input logic [W-1:0]  rf_data,
                                               input logic          f_en,
                                               input logic [RA-1:0] f_addr,
                                               input logic [W-1:0]  f_data);
    if (addr == '0)                    return '0;
    else if (f_en && (f_addr == addr)) return f_data;
    else                               return rf_data;
  endfunction

  dec_t                dec;
  logic [3:0]          imm4;
  logic signed [W-1:0] imm_sext;
  logic [W-1:0]        rs_val, rt_val;
  logic [RA-1:0]       dst;
  logic                accept;

  logic          valid_q, valid_d;
  logic [W-1:0]  alu_x_q, alu_x_d, alu_y_q, alu_y_d, store_q, store_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [RA-1:0] rd_q, rd_d;
  logic          wb_q, wb_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic          branch_q, branch_d, illegal_q, illegal_d;
  logic [15:0]   pc_q, pc_d;

  op_decode u_dec (
    .op  (in_instr[OP_MSB:OP_LSB]),
    .dec (dec)
  );

  assign rs_addr  = in_instr[RS_MSB:RS_LSB];
  assign rt_addr  = in_instr[RT_MSB:RT_LSB];
  assign imm4     = in_instr[IMM_MSB:IMM_LSB];
  assign imm_sext = {{(W-4){imm4[3]}}, imm4};
  assign rs_val   = operand_sel(rs_addr, rs_data, fwd_en, fwd_addr, fwd_data);
  assign rt_val   = operand_sel(rt_addr, rt_data, fwd_en, fwd_addr, fwd_data);
  assign dst      = dec.rd_rt ? rt_addr : imm4;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    alu_op_d  = alu_op_q;
    store_d   = store_q;
    rd_d      = rd_q;
    wb_d      = wb_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    pc_d      = pc_q;
    // Flush wins over both capture and drain.
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      alu_x_d   = rs_val;
      alu_y_d   = dec.y_imm ? imm_sext : rt_val;
      alu_op_d  = dec.alu_op;
      store_d   = dec.mem_wr ? rt_val : '0;
      wb_d      = dec.wb_req && (dst != '0);
      rd_d      = (dec.wb_req && (dst != '0)) ? dst : '0;
      mem_rd_d  = dec.mem_rd;
      mem_wr_d  = dec.mem_wr;
      branch_d  = dec.branch;
      illegal_d = dec.illegal;
      pc_d      = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      alu_op_q  <= '0;
      store_q   <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      alu_op_q  <= alu_op_d;
      store_q   <= store_d;
      rd_q      <= rd_d;
      wb_q      <= wb_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      pc_q      <= pc_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_op     = alu_op_q;
  assign alu_cin    = 1'b0;
  assign store_data = store_q;
  assign out_rd     = rd_q;
  assign wb_en      = wb_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign branch     = branch_q;
  assign out_pc     = pc_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [15:0] in_pc = '0;
  logic [3:0]  rs_addr, rt_addr;
  logic [15:0] rs_data = '0;
  logic [15:0] rt_data = '0;
  logic        fwd_en = 1'b0;
  logic [3:0]  fwd_addr = '0;
  logic [15:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] alu_x, alu_y, store_data, out_pc;
  logic [3:0]  alu_op, out_rd;
  logic        alu_cin, wb_en, mem_rd, mem_wr, branch, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .fwd_en(fwd_en), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_cin(alu_cin),
    .store_data(store_data), .out_rd(out_rd), .wb_en(wb_en), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .branch(branch), .out_pc(out_pc), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] instr, input logic [15:0] pc,
                       input logic [15:0] rsd, input logic [15:0] rtd);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    rs_data  = rsd;
    rt_data  = rtd;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_x", alu_x, 0);
    check("rst_wb", wb_en, 0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();

    // ADD r3 = r1 + r2
    out_ready = 1'b1;
    offer(16'h2123, 16'h0010, 16'h0005, 16'h0003);
    #1;
    check("add_rs_addr", rs_addr, 1);
    check("add_rt_addr", rt_addr, 2);
    step();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_x", alu_x, 16'h0005);
    check("add_y", alu_y, 16'h0003);
    check("add_op", alu_op, 2);
    check("add_rd", out_rd, 3);
    check("add_wb", wb_en, 1);
    check("add_cin", alu_cin, 0);
    check("add_pc", out_pc, 16'h0010);
    step();
    check("drain_valid", out_valid, 0);

    // LW then SW back-to-back
    offer(16'h8418, 16'h0020, 16'h0100, 16'h7777);
    step();
    check("lw_x", alu_x, 16'h0100);
    check("lw_y", alu_y, 16'hFFF8);
    check("lw_rd", out_rd, 1);
    check("lw_mem_rd", mem_rd, 1);
    check("lw_wb", wb_en, 1);
    check("lw_store", store_data, 0);
    offer(16'hA41F, 16'h0022, 16'h0200, 16'h1234);
    step();
    check("sw_valid", out_valid, 1);
    check("sw_y", alu_y, 16'hFFFF);
    check("sw_mem_wr", mem_wr, 1);
    check("sw_mem_rd", mem_rd, 0);
    check("sw_store", store_data, 16'h1234);
    check("sw_wb", wb_en, 0);
    check("sw_rd", out_rd, 0);
    check("sw_op", alu_op, 4'hA);

    // Forwarding beats register file; r0 destination disables writeback
    fwd_en = 1'b1; fwd_addr = 4'd1; fwd_data = 16'hBEEF;
    offer(16'h6120, 16'h0024, 16'h1111, 16'h0022);
    step();
    check("fwd_x", alu_x, 16'hBEEF);
    check("fwd_y", alu_y, 16'h0022);
    check("fwd_rd", out_rd, 0);
    check("fwd_wb", wb_en, 0);
    check("fwd_op", alu_op, 6);

    // r0 source reads zero even when the forward bus targets r0
    fwd_addr = 4'd0;
    offer(16'h2012, 16'h0026, 16'h5555, 16'h0009);
    step();
    fwd_en = 1'b0;
    check("r0_x", alu_x, 0);
    check("r0_y", alu_y, 16'h0009);
    check("r0_rd", out_rd, 2);
    check("r0_wb", wb_en, 1);

    // Backpressure: hold 0x2012 for three cycles while OR is offered
    out_ready = 1'b0;
    offer(16'h1345, 16'h0028, 16'hA0A0, 16'h0505);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      step();
      check("bp_hold_x", alu_x, 0);
      check("bp_hold_rd", out_rd, 2);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rel_valid", out_valid, 1);
    check("rel_op", alu_op, 1);
    check("rel_x", alu_x, 16'hA0A0);
    check("rel_y", alu_y, 16'h0505);
    check("rel_rd", out_rd, 5);
    check("rel_pc", out_pc, 16'h0028);
    step();
    check("rel_still_held", out_valid, 1);
    check("rel_held_pc", out_pc, 16'h0028);
    out_ready = 1'b1;
    step();
    check("rel_no_dup", out_valid, 0);

    // Flush kills held instruction and drops the one offered
    offer(16'h7123, 16'h0030, 16'h0001, 16'h0002);
    step();
    check("slt_valid", out_valid, 1);
    out_ready = 1'b0;
    flush = 1'b1;
    offer(16'h2456, 16'h0032, 16'h0003, 16'h0004);
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    step();
    check("flush_dropped", out_valid, 0);

    // Illegal opcode then BNE
    out_ready = 1'b1;
    offer(16'h3123, 16'h0040, 16'h0005, 16'h0003);
    step();
    check("ill_valid", out_valid, 1);
    check("ill_flag", illegal, 1);
    check("ill_wb", wb_en, 0);
    check("ill_op", alu_op, 0);
    check("ill_rd", out_rd, 0);
    offer(16'hE120, 16'h0042, 16'h0007, 16'h0008);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("bne_branch", branch, 1);
    check("bne_wb", wb_en, 0);
    check("bne_ill", illegal, 0);
    check("bne_x", alu_x, 16'h0007);
    check("bne_y", alu_y, 16'h0008);

    // Asynchronous reset mid-stream, between clock edges
    #1 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_x", alu_x, 0);
    check("arst_branch", branch, 0);
    check("arst_pc", out_pc, 0);
    check("arst_op", alu_op, 0);
    #1 rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
